// File: rtl/phase_pattern_gen.sv
// phase_pattern_gen: V/I sign-bit word generator with a slewed, commanded phase offset
module phase_pattern_gen #(
    parameter int SLEW_STEP = 4,
    parameter int THETA_MAX = 63
) (
    input  logic              clk325kHz_d2,
    input  logic              rst,
    input  logic              en,
    input  logic signed [7:0] theta_cmd,
    input  logic              cmd_load,
    output logic [3:0]        V,
    output logic [3:0]        I,
    output logic              pulse20kHz,
    output logic signed [7:0] theta_applied,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic signed [8:0] STEP = 9'(SLEW_STEP);
    localparam logic signed [7:0] TMAX = 8'(THETA_MAX);

    state_t            state, state_n;
    logic [5:0]        cnt, a, b;
    logic signed [7:0] target, target_n, theta_n, s;
    logic signed [8:0] diff;
    logic [3:0]        v_n, i_n;
    logic              gen, bnd, near;

    // State register
    always_ff @(posedge clk325kHz_d2) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Run/drain sequencing: a drain always finishes the current period before idling
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = en ? RUN : IDLE;
            RUN:     state_n = en ? RUN : DRAIN;
            DRAIN:   state_n = en ? RUN : (cnt == 6'd60 ? IDLE : DRAIN);
            default: state_n = IDLE;
        endcase
    end

    // Target saturation, slewed phase step at the period boundary, and next sample words
    always_comb begin
        gen      = state != IDLE;
        bnd      = state == RUN && cnt == 6'd60;
        target_n = !cmd_load ? target :
                   theta_cmd > TMAX ? TMAX :
                   theta_cmd < -TMAX ? -TMAX : theta_cmd;
        diff     = {target[7], target} - {theta_applied[7], theta_applied};
        near     = SLEW_STEP == 0 || (diff <= STEP && diff >= -STEP);
        theta_n  = !bnd ? theta_applied :
                   near ? target :
                   diff > 0 ? theta_applied + STEP[7:0] : theta_applied - STEP[7:0];
        s        = $signed(theta_applied + {7'd0, theta_applied[7]}) >>> 1;
        a        = '0;
        b        = '0;
        v_n      = '0;
        i_n      = '0;
        for (int k = 0; k < 4; k++) begin
            a      = cnt + 6'(k);
            b      = a + s[5:0];
            v_n[k] = ~a[5];
            i_n[k] = ~b[5];
        end
    end

    // Registered outputs; the sample counter only moves while words are being generated
    always_ff @(posedge clk325kHz_d2) begin
        if (rst) begin
            cnt           <= '0;
            V             <= '0;
            I             <= '0;
            pulse20kHz    <= 1'b0;
            target        <= '0;
            theta_applied <= '0;
            busy          <= 1'b0;
        end else begin
            cnt           <= gen ? cnt + 6'd4 : 6'd0;
            V             <= gen ? v_n : 4'd0;
            I             <= gen ? i_n : 4'd0;
            pulse20kHz    <= gen && cnt == 6'd60;
            target        <= target_n;
            theta_applied <= theta_n;
            busy          <= theta_n != target_n;
        end
    end
endmodule
